// File: rtl/rs_ff_response_checker_pkg.sv
// Shared encodings for the RS flip-flop response checker: FSM states, the
// {R,S} input codes, and the response-compare helper.
package rs_ff_chk_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } rs_state_e;

    localparam logic [1:0] RS_HOLD = 2'b00;
    localparam logic [1:0] RS_SET  = 2'b01;
    localparam logic [1:0] RS_RST  = 2'b10;
    localparam logic [1:0] RS_BAD  = 2'b11;

    // A response is wrong when Q disagrees with the model or Q_N is not its complement.
    function automatic logic rs_mismatch(input logic q, input logic q_n, input logic exp_q);
        return (q != exp_q) | (q_n == q);
    endfunction

endpackage

// File: rtl/rs_ff_response_checker_if.sv
// Observation bundle between the RS flip-flop environment and the checker:
// sampled stimulus/response in, model state and statistics out.
interface rs_ff_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             EN;
    logic             CLR;
    logic             R;
    logic             S;
    logic             Q;
    logic             Q_N;
    logic             EXP_Q;
    logic             EXP_VALID;
    logic             ERR;
    logic             INVALID;
    logic             FAULT;
    logic [CNT_W-1:0] ERR_CNT;
    logic [CNT_W-1:0] SET_CNT;
    logic [CNT_W-1:0] RST_CNT;
    logic [1:0]       STATE;

    modport master (
        output EN, CLR, R, S, Q, Q_N,
        input  EXP_Q, EXP_VALID, ERR, INVALID, FAULT, ERR_CNT, SET_CNT, RST_CNT, STATE
    );

    modport slave (
        input  EN, CLR, R, S, Q, Q_N,
        output EXP_Q, EXP_VALID, ERR, INVALID, FAULT, ERR_CNT, SET_CNT, RST_CNT, STATE
    );

endinterface

// File: rtl/rs_ff_response_checker_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] MAX_C  = {W{1'b1}};
    localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r <= ZERO_C;
        end else if (clr) begin
            cnt_r <= ZERO_C;
        end else if (inc && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/rs_ff_response_checker.sv
// Passive checker for a clocked RS flip-flop: predicts Q from the applied R/S
// code and flags any DUT response that disagrees on the following edge.
module rs_ff_response_checker
    import rs_ff_chk_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 4
) (
    input logic                     CLK,
    input logic                     RST_N,
    rs_ff_response_checker_if.slave bus
);
    localparam logic [CNT_W:0] LIMIT_C = (CNT_W+1)'(ERR_LIMIT);
    localparam logic [CNT_W:0] ONE_C   = {{CNT_W{1'b0}}, 1'b1};

    rs_state_e        state_r;
    rs_state_e        state_nxt_s;
    logic             exp_q_r;
    logic             exp_q_nxt_s;
    logic             exp_valid_r;
    logic             exp_valid_nxt_s;
    logic             pending_r;
    logic             err_r;
    logic             invalid_r;
    logic             invalid_nxt_s;
    logic             fault_r;
    logic             sample_s;
    logic             check_s;
    logic             mismatch_s;
    logic             limit_hit_s;
    logic             set_inc_s;
    logic             rst_inc_s;
    logic [1:0]       rs_s;
    logic [CNT_W-1:0] err_cnt_s;
    logic [CNT_W-1:0] set_cnt_s;
    logic [CNT_W-1:0] rst_cnt_s;

    // Edge qualifiers; the compare uses the model value registered on the previous edge.
    always_comb begin
        sample_s    = bus.EN & ~bus.CLR;
        rs_s        = {bus.R, bus.S};
        check_s     = sample_s & pending_r & exp_valid_r;
        mismatch_s  = check_s & rs_mismatch(bus.Q, bus.Q_N, exp_q_r);
        limit_hit_s = mismatch_s & (({1'b0, err_cnt_s} + ONE_C) >= LIMIT_C);
        set_inc_s   = sample_s & (rs_s == RS_SET);
        rst_inc_s   = sample_s & (rs_s == RS_RST);
    end

    // Next-state for the truth-table model and the tracking FSM.
    always_comb begin
        state_nxt_s     = state_r;
        exp_q_nxt_s     = exp_q_r;
        exp_valid_nxt_s = exp_valid_r;
        invalid_nxt_s   = 1'b0;
        if (bus.CLR) begin
            state_nxt_s     = ST_UNKNOWN;
            exp_q_nxt_s     = 1'b0;
            exp_valid_nxt_s = 1'b0;
        end else if (sample_s) begin
            case (rs_s)
                RS_SET: begin
                    exp_q_nxt_s     = 1'b1;
                    exp_valid_nxt_s = 1'b1;
                end
                RS_RST: begin
                    exp_q_nxt_s     = 1'b0;
                    exp_valid_nxt_s = 1'b1;
                end
                RS_BAD: begin
                    exp_valid_nxt_s = 1'b0;
                    invalid_nxt_s   = 1'b1;
                end
                default: begin
                    exp_q_nxt_s = exp_q_r;
                end
            endcase
            // FAULT is sticky; an illegal code there only drops EXP_VALID.
            case (state_r)
                ST_UNKNOWN: begin
                    if ((rs_s == RS_SET) || (rs_s == RS_RST)) begin
                        state_nxt_s = ST_TRACK;
                    end else begin
                        state_nxt_s = ST_UNKNOWN;
                    end
                end
                ST_TRACK: begin
                    if (limit_hit_s) begin
                        state_nxt_s = ST_FAULT;
                    end else if (rs_s == RS_BAD) begin
                        state_nxt_s = ST_UNKNOWN;
                    end else begin
                        state_nxt_s = ST_TRACK;
                    end
                end
                ST_FAULT: begin
                    state_nxt_s = ST_FAULT;
                end
                default: begin
                    state_nxt_s = ST_UNKNOWN;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_UNKNOWN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Model, pending-check flag and registered status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            exp_q_r     <= 1'b0;
            exp_valid_r <= 1'b0;
            pending_r   <= 1'b0;
            err_r       <= 1'b0;
            invalid_r   <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            exp_q_r     <= exp_q_nxt_s;
            exp_valid_r <= exp_valid_nxt_s;
            pending_r   <= sample_s;
            err_r       <= mismatch_s;
            invalid_r   <= invalid_nxt_s;
            fault_r     <= (state_nxt_s == ST_FAULT);
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (bus.CLR),
        .inc   (mismatch_s),
        .cnt   (err_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_set_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (bus.CLR),
        .inc   (set_inc_s),
        .cnt   (set_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_rst_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (bus.CLR),
        .inc   (rst_inc_s),
        .cnt   (rst_cnt_s)
    );

    assign bus.EXP_Q     = exp_q_r;
    assign bus.EXP_VALID = exp_valid_r;
    assign bus.ERR       = err_r;
    assign bus.INVALID   = invalid_r;
    assign bus.FAULT     = fault_r;
    assign bus.ERR_CNT   = err_cnt_s;
    assign bus.SET_CNT   = set_cnt_s;
    assign bus.RST_CNT   = rst_cnt_s;
    assign bus.STATE     = state_r;

endmodule
